// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: FSM state encoding
// and stream-to-word packing constants.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 4-byte pack register: i_load writes byte at index, i_clear resets.
// Ports: clk, rst (async low), i_clear, i_load, i_byte -> o_word, o_full.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clear,
  input  logic                          i_load,
  input  logic [7:0]                    i_byte,
  output logic [8*BYTES_PER_WORD-1:0]   o_word,
  output logic                          o_full
);

  logic [1:0]                  r_idx;
  logic [8*BYTES_PER_WORD-1:0] r_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_load) begin
      r_word[{r_idx, 3'b000} +: 8] <= i_byte;
      r_idx                        <= r_idx + 2'd1;
    end
  end

  // Not gated by i_load: the next load completes
  // the word, and the caller qualifies it.
  assign o_full = (r_idx == 2'(BYTES_PER_WORD - 1));
  assign o_word = r_word;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream into words and writes them to imem.
// Ports: start/num_words/abort, byte valid/ready stream, imem write, status.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             abort,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             error
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_word_idx;
  logic [CNT_W-1:0] r_num_words;
  logic             r_error;
  logic             w_num_ok;
  logic             w_accept;
  logic             w_last;
  logic             w_clear;
  logic             w_load;
  logic             w_full;
  logic [31:0]      w_word;
  logic [31:0]      w_offs;

  assign w_num_ok = (num_words != '0) &&
                    (num_words <= CNT_W'(DEPTH_WORDS));
  assign w_accept = (r_state == ST_IDLE) && start && w_num_ok;
  assign w_last   = (r_word_idx == r_num_words - CNT_W'(1));

  imem_loader_byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_load  (w_load),
    .i_byte  (byte_data),
    .o_word  (w_word),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    done       = 1'b0;
    w_clear    = 1'b0;
    w_load     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next  = ST_RECV;
          w_clear = 1'b1;
        end
      end
      ST_RECV: begin
        byte_ready = 1'b1;
        // abort beats a same-cycle byte
        if (abort) begin
          w_next  = ST_IDLE;
          w_clear = 1'b1;
        end else if (byte_valid) begin
          w_load = 1'b1;
          if (w_full) w_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        imem_we = 1'b1;
        if (abort) begin
          w_next  = ST_IDLE;
          w_clear = 1'b1;
        end else if (w_last) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_RECV;
        end
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word_idx  <= '0;
      r_num_words <= '0;
      r_error     <= 1'b0;
    end else begin
      r_error <= (r_state == ST_IDLE) && start && !w_num_ok;
      if (w_accept) begin
        r_num_words <= num_words;
        r_word_idx  <= '0;
      end else if (r_state == ST_WRITE && !abort && !w_last) begin
        r_word_idx <= r_word_idx + CNT_W'(1);
      end
    end
  end

  assign w_offs     = 32'(r_word_idx) << 2;
  assign imem_addr  = imem_we ? (BASE_ADDR + w_offs) : 32'h0;
  assign imem_wdata = imem_we ? w_word : 32'h0;
  assign busy       = (r_state != ST_IDLE);
  assign cpu_hold   = busy;
  assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
// Drives/samples on the falling edge.
module tb_imem_loader;

  localparam int DEPTH = 256;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_words = '0;
  logic          abort = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready;
  logic          imem_we;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;

  imem_loader #(
    .BASE_ADDR   (32'h0000_0000),
    .DEPTH_WORDS (DEPTH),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_words  (num_words),
    .abort      (abort),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  int          cyc = 0;
  int          we_cnt, done_cnt, err_cnt;
  int          busy_cnt, hold_cnt, ovl_cnt;
  int          rec_cyc, done_cyc, drop_cyc;
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];

  task automatic clr();
    we_cnt   = 0;
    done_cnt = 0;
    err_cnt  = 0;
    busy_cnt = 0;
    hold_cnt = 0;
    ovl_cnt  = 0;
    rec_cyc  = -1;
    done_cyc = -1;
    drop_cyc = -1;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (imem_we) begin
      if (we_cnt < 16) begin
        wr_addr[we_cnt] = imem_addr;
        wr_data[we_cnt] = imem_wdata;
      end
      we_cnt++;
      if (byte_ready) ovl_cnt++;
    end
    if (byte_ready && rec_cyc < 0) rec_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (error)    err_cnt++;
    if (busy)     busy_cnt++;
    if (cpu_hold) hold_cnt++;
    if (done_cyc >= 0 && !cpu_hold && drop_cyc < 0)
      drop_cyc = cyc;
  end

  task automatic do_start(input int n);
    start     = 1'b1;
    num_words = CW'(n);
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int gap);
    int t;
    t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("byte_timeout", 32'(t), 32'd0);
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w,
                           input int gap);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], gap);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("idle_timeout", 32'(t), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    clr();
    #2;
    chk("rst_ctl", {26'd0, byte_ready, imem_we,
                    cpu_hold, busy, done, error}, 32'd0);
    chk("rst_addr",  imem_addr,  32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // nominal 2-word load
    clr();
    do_start(2);
    send_word(32'h1234_5678, 0);
    send_word(32'hDEAD_BEEF, 0);
    wait_idle();
    chk("nom_we_cnt", 32'(we_cnt), 32'd2);
    chk("nom_addr0",  wr_addr[0], 32'h0000_0000);
    chk("nom_data0",  wr_data[0], 32'h1234_5678);
    chk("nom_addr1",  wr_addr[1], 32'h0000_0004);
    chk("nom_data1",  wr_data[1], 32'hDEAD_BEEF);
    chk("nom_done",   32'(done_cnt), 32'd1);
    chk("nom_lat",    32'(done_cyc - rec_cyc), 32'd10);
    chk("nom_drop",   32'(drop_cyc - done_cyc), 32'd1);
    chk("nom_err",    32'(err_cnt), 32'd0);

    // backpressure: 3 idle cycles between bytes
    clr();
    do_start(2);
    send_word(32'h1234_5678, 3);
    send_word(32'hDEAD_BEEF, 3);
    wait_idle();
    chk("bp_we_cnt", 32'(we_cnt), 32'd2);
    chk("bp_data0",  wr_data[0], 32'h1234_5678);
    chk("bp_addr1",  wr_addr[1], 32'h0000_0004);
    chk("bp_data1",  wr_data[1], 32'hDEAD_BEEF);
    chk("bp_ovl",    32'(ovl_cnt), 32'd0);
    chk("bp_done",   32'(done_cnt), 32'd1);

    // rejection
    clr();
    do_start(0);
    repeat (3) @(negedge clk);
    chk("rej0_err",  32'(err_cnt), 32'd1);
    chk("rej0_busy", 32'(busy_cnt + hold_cnt + we_cnt), 32'd0);
    clr();
    do_start(DEPTH + 1);
    repeat (3) @(negedge clk);
    chk("rej1_err",  32'(err_cnt), 32'd1);
    chk("rej1_busy", 32'(busy_cnt + hold_cnt + we_cnt), 32'd0);

    // DEPTH_WORDS is accepted; abort it at once
    clr();
    do_start(DEPTH);
    chk("max_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("max_abort", {31'd0, busy}, 32'd0);
    chk("max_err",   32'(err_cnt), 32'd0);

    // abort after 6 bytes, with a same-cycle byte
    clr();
    do_start(4);
    send_word(32'h0403_0201, 0);
    send_byte(8'h05, 0);
    send_byte(8'h06, 0);
    abort      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    @(negedge clk);
    abort      = 1'b0;
    byte_valid = 1'b0;
    chk("ab_idle", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    chk("ab_we_cnt", 32'(we_cnt), 32'd1);
    chk("ab_addr0",  wr_addr[0], 32'h0000_0000);
    chk("ab_data0",  wr_data[0], 32'h0403_0201);
    chk("ab_done",   32'(done_cnt), 32'd0);
    clr();
    do_start(1);
    send_word(32'h4433_2211, 0);
    wait_idle();
    chk("ab2_we_cnt", 32'(we_cnt), 32'd1);
    chk("ab2_addr",   wr_addr[0], 32'h0000_0000);
    chk("ab2_data",   wr_data[0], 32'h4433_2211);

    // async reset mid-word
    clr();
    do_start(2);
    send_byte(8'hC1, 0);
    send_byte(8'hC2, 0);
    #2 rst = 1'b0;
    #1;
    chk("ar_ctl", {26'd0, byte_ready, imem_we,
                   cpu_hold, busy, done, error}, 32'd0);
    chk("ar_addr", imem_addr | imem_wdata, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("ar_nowr", 32'(we_cnt + done_cnt), 32'd0);
    clr();
    do_start(1);
    send_word(32'hA4A3_A2A1, 0);
    wait_idle();
    chk("ar2_we_cnt", 32'(we_cnt), 32'd1);
    chk("ar2_addr",   wr_addr[0], 32'h0000_0000);
    chk("ar2_data",   wr_data[0], 32'hA4A3_A2A1);

    // start while busy is ignored
    clr();
    do_start(2);
    send_byte(8'h78, 0);
    start     = 1'b1;
    num_words = CW'(9);
    send_byte(8'h56, 0);
    start     = 1'b0;
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    send_word(32'hCAFE_F00D, 0);
    wait_idle();
    chk("sb_we_cnt", 32'(we_cnt), 32'd2);
    chk("sb_data0",  wr_data[0], 32'h1234_5678);
    chk("sb_data1",  wr_data[1], 32'hCAFE_F00D);
    chk("sb_done",   32'(done_cnt), 32'd1);
    chk("sb_err",    32'(err_cnt), 32'd0);
    chk("sb_idle",   {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
